// File: rtl/mic_volume_meter_pkg.sv
// ============================================================================
//  Module   : mic_pkg
//  Purpose  : Shared widths, code-point helpers and level quantiser for the
//             microphone volume meter and its consumers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mic_pkg;

  // Default mic sample width (unsigned offset-binary)
  localparam int unsigned DEF_SAMPLE_W = 12;
  // Default published level width; the game block sizes its volume input from this
  localparam int unsigned DEF_LEVEL_W  = 5;

  // Mid-scale code for a given sample width: 2^(w-1)
  function automatic int unsigned mid_code(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Full-scale code for a given sample width: 2^w - 1
  function automatic int unsigned full_code(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Quantise an amplitude to a level by dropping the low-order bits
  function automatic int unsigned amp_to_level(input int unsigned amp,
                                               input int unsigned shift);
    return amp >> shift;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mic_volume_meter_if.sv
// ============================================================================
//  Module   : mic_volume_meter_if
//  Purpose  : Sample stream in / volume level out bundle of the volume meter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mic_volume_meter_if
  import mic_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
  parameter int unsigned LEVEL_W  = DEF_LEVEL_W
);

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic [LEVEL_W-1:0]  volume;
  logic                volume_valid;
  logic                clip;

  // Sample producer / level consumer side
  modport master (
    output sample_valid, sample,
    input  volume, volume_valid, clip
  );

  // Volume meter side
  modport slave (
    input  sample_valid, sample,
    output volume, volume_valid, clip
  );

endinterface

`default_nettype wire

// File: rtl/mic_volume_meter_amplitude.sv
// ============================================================================
//  Module   : mic_amplitude
//  Purpose  : Stage 1 - absolute deviation from mid-scale plus clip detect,
//             registered together with a valid bit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mic_amplitude
  import mic_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                valid_i,
  input  wire logic [SAMPLE_W-1:0] sample_i,
  output logic      [SAMPLE_W-2:0] amp_o,
  output logic                     is_clip_o,
  output logic                     valid_o
);

  localparam logic [SAMPLE_W-1:0] C_MID  = SAMPLE_W'(mid_code(SAMPLE_W));
  localparam logic [SAMPLE_W-1:0] C_FULL = SAMPLE_W'(full_code(SAMPLE_W));

  logic [SAMPLE_W-2:0] amp_d, amp_q;
  logic                is_clip_d, is_clip_q;
  logic                valid_q;

  // Fold the sample about mid-scale; both rails count as clipping
  always_comb begin
    amp_d     = '0;
    is_clip_d = (sample_i == '0) || (sample_i == C_FULL);
    if (sample_i >= C_MID) begin
      amp_d = (SAMPLE_W-1)'(sample_i - C_MID);
    end else begin
      amp_d = (SAMPLE_W-1)'(C_MID - 1'b1 - sample_i);
    end
  end

  // Capture amplitude/clip only for valid samples; valid follows the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amp_q     <= '0;
      is_clip_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        amp_q     <= amp_d;
        is_clip_q <= is_clip_d;
      end
    end
  end

  assign amp_o     = amp_q;
  assign is_clip_o = is_clip_q;
  assign valid_o   = valid_q;

endmodule

`default_nettype wire

// File: rtl/mic_volume_meter.sv
// ============================================================================
//  Module   : mic_volume_meter
//  Purpose  : Windowed peak meter: per WINDOW samples, publish the quantised
//             peak deviation from mid-scale with a one-cycle valid pulse and a
//             clip flag. Closing sample to publish latency is 3 cycles.
//  Options  : MIC_VOLUME_HOLD_EN - peak-hold with one-level-per-window decay.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mic_volume_meter
  import mic_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W,
  parameter int unsigned LEVEL_W     = DEF_LEVEL_W,
  parameter int unsigned WINDOW      = 4000,
  parameter int unsigned NOISE_FLOOR = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mic_volume_meter_if.slave bus
);

  localparam int unsigned     AMP_W = SAMPLE_W - 1;
  localparam int unsigned     CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned     SHIFT = SAMPLE_W - 1 - LEVEL_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  // Stage 1 outputs
  logic [AMP_W-1:0] s1_amp;
  logic             s1_clip;
  logic             s1_v;

  // Stage 2 state
  logic [AMP_W-1:0] peak_d, peak_q;
  logic             clip_acc_d, clip_acc_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [AMP_W-1:0] snap_peak_d, snap_peak_q;
  logic             snap_clip_d, snap_clip_q;
  logic             snap_v_d, snap_v_q;
  logic [AMP_W-1:0] max_amp;

  // Stage 3 state
  logic [LEVEL_W-1:0] level_raw, level;
  logic [LEVEL_W-1:0] volume_d, volume_q;
  logic [LEVEL_W-1:0] new_volume;
  logic               clip_d, clip_q;
  logic               vv_d, vv_q;

  mic_amplitude #(
    .SAMPLE_W (SAMPLE_W)
  ) u_amp (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (bus.sample_valid),
    .sample_i  (bus.sample),
    .amp_o     (s1_amp),
    .is_clip_o (s1_clip),
    .valid_o   (s1_v)
  );

  // Stage 2: track the window peak; the closing sample snapshots and re-arms
  always_comb begin
    peak_d      = peak_q;
    clip_acc_d  = clip_acc_q;
    cnt_d       = cnt_q;
    snap_peak_d = snap_peak_q;
    snap_clip_d = snap_clip_q;
    snap_v_d    = 1'b0;
    max_amp     = (s1_amp > peak_q) ? s1_amp : peak_q;
    if (s1_v) begin
      if (cnt_q == LAST) begin
        snap_peak_d = max_amp;
        snap_clip_d = clip_acc_q | s1_clip;
        snap_v_d    = 1'b1;
        peak_d      = '0;
        clip_acc_d  = 1'b0;
        cnt_d       = '0;
      end else begin
        peak_d      = max_amp;
        clip_acc_d  = clip_acc_q | s1_clip;
        cnt_d       = cnt_q + 1'b1;
      end
    end
  end

  // Stage 3: quantise the snapshot and gate out the noise floor
  always_comb begin
    level_raw = LEVEL_W'(amp_to_level(32'(snap_peak_q), SHIFT));
    level     = (32'(level_raw) < NOISE_FLOOR) ? '0 : level_raw;
  end

`ifdef MIC_VOLUME_HOLD_EN
  logic [LEVEL_W-1:0] decayed;

  // Remembered level falls by one per window, never below zero
  always_comb begin
    decayed    = (volume_q == '0) ? '0 : volume_q - 1'b1;
    new_volume = (level > decayed) ? level : decayed;
  end
`else
  // Output follows the latest window directly
  always_comb begin
    new_volume = level;
  end
`endif

  // Stage 3 publish: outputs change only on a snapshot
  always_comb begin
    volume_d = volume_q;
    clip_d   = clip_q;
    vv_d     = snap_v_q;
    if (snap_v_q) begin
      volume_d = new_volume;
      clip_d   = snap_clip_q;
    end
  end

  // Pipeline registers for stages 2 and 3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q      <= '0;
      clip_acc_q  <= 1'b0;
      cnt_q       <= '0;
      snap_peak_q <= '0;
      snap_clip_q <= 1'b0;
      snap_v_q    <= 1'b0;
      volume_q    <= '0;
      clip_q      <= 1'b0;
      vv_q        <= 1'b0;
    end else begin
      peak_q      <= peak_d;
      clip_acc_q  <= clip_acc_d;
      cnt_q       <= cnt_d;
      snap_peak_q <= snap_peak_d;
      snap_clip_q <= snap_clip_d;
      snap_v_q    <= snap_v_d;
      volume_q    <= volume_d;
      clip_q      <= clip_d;
      vv_q        <= vv_d;
    end
  end

  assign bus.volume       = volume_q;
  assign bus.volume_valid = vv_q;
  assign bus.clip         = clip_q;

endmodule

`default_nettype wire

// File: tb/tb_mic_volume_meter.sv
// ============================================================================
//  Module   : tb_mic_volume_meter
//  Purpose  : Directed self-checking bench for mic_volume_meter (WINDOW=4 and
//             WINDOW=1 instances). Expectations follow MIC_VOLUME_HOLD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mic_volume_meter;

`ifdef MIC_VOLUME_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mic_volume_meter_if #(.SAMPLE_W(12), .LEVEL_W(5)) bus4 ();
  mic_volume_meter_if #(.SAMPLE_W(12), .LEVEL_W(5)) bus1 ();

  mic_volume_meter #(.SAMPLE_W(12), .LEVEL_W(5), .WINDOW(4), .NOISE_FLOOR(2)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  mic_volume_meter #(.SAMPLE_W(12), .LEVEL_W(5), .WINDOW(1), .NOISE_FLOOR(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic vv, input int vol, input logic cl);
    chk({tag, ".vv"},   32'(bus4.volume_valid), 32'(vv));
    chk({tag, ".vol"},  32'(bus4.volume),       32'(vol));
    chk({tag, ".clip"}, 32'(bus4.clip),         32'(cl));
  endtask

  task automatic chk1(input string tag, input logic vv, input int vol, input logic cl);
    chk({tag, ".vv"},   32'(bus1.volume_valid), 32'(vv));
    chk({tag, ".vol"},  32'(bus1.volume),       32'(vol));
    chk({tag, ".clip"}, 32'(bus1.clip),         32'(cl));
  endtask

  task automatic put4(input int s);
    @(negedge clk);
    bus4.sample_valid = 1'b1;
    bus4.sample       = 12'(s);
  endtask

  task automatic idle4();
    @(negedge clk);
    bus4.sample_valid = 1'b0;
    bus4.sample       = 12'd2048;
  endtask

  // Four-sample window followed by the expected pulse exactly 3 cycles later
  task automatic window4(input string tag, input int s0, input int s1, input int s2,
                         input int s3, input int vol, input logic cl, input int prev);
    put4(s0); put4(s1); put4(s2); put4(s3);
    idle4(); chk({tag, ".n1"}, 32'(bus4.volume_valid), 32'd0);
    idle4(); chk({tag, ".n2"}, 32'(bus4.volume_valid), 32'd0);
    chk({tag, ".n2vol"}, 32'(bus4.volume), 32'(prev));
    idle4(); chk4({tag, ".pub"}, 1'b1, vol, cl);
    idle4(); chk4({tag, ".after"}, 1'b0, vol, cl);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus4.sample_valid = 1'b0;
    bus4.sample       = 12'd2048;
    bus1.sample_valid = 1'b0;
    bus1.sample       = 12'd2048;

    // Reset values
    repeat (3) @(negedge clk);
    chk4("rst4", 1'b0, 0, 1'b0);
    chk1("rst1", 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle.vv", 32'({bus4.volume_valid, bus1.volume_valid}), 32'd0);
    end

    // Quiet, peak capture, noise floor, clip, hold/drop behaviour
    window4("quiet", 2048, 2048, 2048, 2048, 0, 1'b0, 0);
    window4("peak",  2048, 3000, 1000, 2100, 16, 1'b0, 0);
    window4("nf1",   2148, 2048, 2048, 2048, HOLD ? 15 : 0, 1'b0, 16);
    window4("nf2",   2048, 2200, 2048, 2048, HOLD ? 14 : 2, 1'b0, HOLD ? 15 : 0);
    window4("clipH", 2048, 2048, 4095, 2048, 31, 1'b1, HOLD ? 14 : 2);
    window4("q1",    2048, 2048, 2048, 2048, HOLD ? 30 : 0, 1'b0, 31);
    window4("q2",    2048, 2048, 2048, 2048, HOLD ? 29 : 0, 1'b0, HOLD ? 30 : 0);
    window4("q3",    2048, 2048, 2048, 2048, HOLD ? 28 : 0, 1'b0, HOLD ? 29 : 0);
    window4("clipL", 0,    2048, 2048, 2048, 31, 1'b1, HOLD ? 28 : 0);

    // Reset two samples into a window: stale peak/clip/count must vanish
    put4(4095); put4(4095);
    idle4();
    rst_n = 1'b0;
    #1;
    chk4("rstmid", 1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle4(); chk("rstmid.vv", 32'(bus4.volume_valid), 32'd0);
    window4("postrst", 2048, 2048, 2048, 2200, 2, 1'b0, 0);

    // Back-to-back windows with no gap across the boundary
    put4(4095); put4(2048); put4(2048); put4(2048);
    put4(2048);
    put4(2048); chk("b2b.a5", 32'(bus4.volume_valid), 32'd0);
    put4(2048); chk4("b2b.pubA", 1'b1, 31, 1'b1);
    put4(2148); chk4("b2b.a7", 1'b0, 31, 1'b1);
    idle4(); chk("b2b.a8", 32'(bus4.volume_valid), 32'd0);
    idle4(); chk("b2b.a9", 32'(bus4.volume_valid), 32'd0);
    idle4(); chk4("b2b.pubB", 1'b1, HOLD ? 30 : 0, 1'b0);
    idle4(); chk("b2b.a11", 32'(bus4.volume_valid), 32'd0);

    // WINDOW=1: every sample publishes on consecutive cycles
    @(negedge clk); bus1.sample_valid = 1'b1; bus1.sample = 12'd4095;
    @(negedge clk); bus1.sample = 12'd2048;
    @(negedge clk); bus1.sample = 12'd2200;
    @(negedge clk); bus1.sample_valid = 1'b0; bus1.sample = 12'd2048;
    chk1("w1.p0", 1'b1, 31, 1'b1);
    @(negedge clk); chk1("w1.p1", 1'b1, HOLD ? 30 : 0, 1'b0);
    @(negedge clk); chk1("w1.p2", 1'b1, HOLD ? 29 : 2, 1'b0);
    @(negedge clk); chk1("w1.end", 1'b0, HOLD ? 29 : 2, 1'b0);

    // Outputs hold with no samples
    repeat (5) @(negedge clk);
    chk4("hold4", 1'b0, HOLD ? 30 : 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
